message_sender: RTL and testbench

- Sequencer that reads a stored message out of a 1-cycle-latency registered message ROM and feeds it byte by byte to the UART transmitter.
- Sits between the message ROM (addr in, registered data out) and uart_tx (data/new_data in, busy/block out).
- Triggered by a start pulse or by a matching character arriving from uart_rx.
- Sends bytes 0..MSG_LEN-1 in order, then returns to idle.

---
 rtl/message_sender_if.sv | 36 +++
 rtl/message_sender.sv | 132 +++++++++++++
 tb/tb_message_sender.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/message_sender_if.sv
`default_nettype none
// ============================================================================
// Module      : message_sender_if
// Description : Bundle of the signals around the message sequencer: trigger
//               inputs (start, uart_rx byte), message ROM address/data, and
//               the uart_tx handshake plus status outputs.
//               master : the sequencer (drives rom_addr, tx_*, busy, done)
//               slave  : the surroundings (ROM, uart_rx/uart_tx, controller)
// Revision    : 1.0 - initial release
// ============================================================================
interface message_sender_if #(
    parameter int ADDR_W = 4
);
    logic              start;        // single-cycle send request
    logic [7:0]        rx_data;      // byte from uart_rx
    logic              new_rx_data;  // rx_data valid this cycle
    logic [ADDR_W-1:0] rom_addr;     // address to the message ROM
    logic [7:0]        rom_data;     // ROM output for the previous rom_addr
    logic [7:0]        tx_data;      // byte to uart_tx
    logic              tx_new_data;  // tx_data valid strobe
    logic              tx_busy;      // uart_tx is shifting
    logic              tx_block;     // downstream back-pressure
    logic              busy;         // message in progress
    logic              done;         // pulse after the last byte is handed off

    modport master (
        input  start, rx_data, new_rx_data, rom_data, tx_busy, tx_block,
        output rom_addr, tx_data, tx_new_data, busy, done
    );

    modport slave (
        output start, rx_data, new_rx_data, rom_data, tx_busy, tx_block,
        input  rom_addr, tx_data, tx_new_data, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/message_sender.sv
`default_nettype none
// ============================================================================
// Module      : message_sender
// Description : Reads a stored message out of a registered (1-cycle latency)
//               message ROM and hands it byte by byte to uart_tx. A message
//               is launched by a start pulse or by receiving the TRIGGER
//               character from uart_rx. Bytes 0..MSG_LEN-1 are sent in order.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous reset, active-high
//               bus  - message_sender_if.master: start/rx_data/new_rx_data in,
//                      rom_addr out / rom_data in, tx_data/tx_new_data out,
//                      tx_busy/tx_block in, busy/done out
// Revision    : 1.0 - initial release
// ============================================================================
module message_sender #(
    parameter int         MSG_LEN = 16,
    parameter int         ADDR_W  = 4,
    parameter logic [7:0] TRIGGER = 8'h68
) (
    input  wire logic          clk,
    input  wire logic          rst,
    message_sender_if.master   bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_SEND  = 2'd2;
    localparam logic [1:0] c_GAP   = 2'd3;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(MSG_LEN - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [7:0]        r_tx_data;
    logic              r_tx_new_data;
    logic              r_busy;
    logic              r_done;

    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_rom_addr_nxt;
    logic [7:0]        w_tx_data_nxt;
    logic              w_tx_new_data_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    logic              w_trigger;
    logic              w_tx_ready;
    logic              w_last;

    // Both trigger sources in one cycle collapse into a single request.
    assign w_trigger  = bus.start | (bus.new_rx_data & (bus.rx_data == TRIGGER));
    assign w_tx_ready = ~bus.tx_busy & ~bus.tx_block;
    assign w_last     = (r_rom_addr == c_LAST_ADDR);

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_rom_addr    <= '0;
            r_tx_data     <= '0;
            r_tx_new_data <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rom_addr    <= w_rom_addr_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_tx_new_data <= w_tx_new_data_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_trigger)  w_state_nxt = c_FETCH;
            // One cycle for the ROM to register data at the held address.
            c_FETCH: w_state_nxt = c_SEND;
            c_SEND:  if (w_tx_ready) w_state_nxt = c_GAP;
            // uart_tx raises busy one cycle after the strobe; GAP keeps the
            // next SEND from seeing a stale tx_busy=0.
            c_GAP:   w_state_nxt = w_last ? c_IDLE : c_FETCH;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next values of the registered outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_rom_addr_nxt    = r_rom_addr;
        w_tx_data_nxt     = r_tx_data;
        w_tx_new_data_nxt = 1'b0;
        w_done_nxt        = 1'b0;
        w_busy_nxt        = (w_state_nxt != c_IDLE);

        case (r_state)
            c_SEND: begin
                if (w_tx_ready) begin
                    w_tx_data_nxt     = bus.rom_data;
                    w_tx_new_data_nxt = 1'b1;
                end
            end
            c_GAP: begin
                if (w_last) begin
                    w_rom_addr_nxt = '0;
                    w_done_nxt     = 1'b1;
                end else begin
                    w_rom_addr_nxt = r_rom_addr + c_ADDR_ONE;
                end
            end
            default: begin
                w_rom_addr_nxt = r_rom_addr;
            end
        endcase
    end

    assign bus.rom_addr    = r_rom_addr;
    assign bus.tx_data     = r_tx_data;
    assign bus.tx_new_data = r_tx_new_data;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_message_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_message_sender
// Description : Self-checking bench for message_sender. A message ROM and a
//               uart_tx busy model surround the DUT; a transaction-level
//               reference model predicts busy/done/strobes/bytes per cycle.
//               A second instance with MSG_LEN=1 covers the single-byte case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_message_sender;

    localparam int         ADDR_W  = 4;
    localparam int         MSG_LEN = 16;
    localparam logic [7:0] TRIG    = 8'h68;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // "Hello \n\rWorld!\n\r"
    logic [7:0] msg [16] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h0a, 8'h0d,
                             8'h57, 8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h0a, 8'h0d};

    message_sender_if #(.ADDR_W(ADDR_W)) bus  ();
    message_sender_if #(.ADDR_W(ADDR_W)) bus1 ();

    message_sender #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W), .TRIGGER(TRIG)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    message_sender #(.MSG_LEN(1), .ADDR_W(ADDR_W), .TRIGGER(TRIG)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Registered message ROMs
    always @(posedge clk) bus.rom_data  <= msg[bus.rom_addr];
    always @(posedge clk) bus1.rom_data <= msg[bus1.rom_addr];

    // uart_tx model: busy rises the cycle after a strobe and lasts 20 cycles
    int tx_cnt = 0;
    always @(posedge clk) begin
        if (bus.tx_new_data) tx_cnt <= 20;
        else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    end
    assign bus.tx_busy = (tx_cnt != 0);

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: message-level view
    //   m_active  : a message is in progress this cycle
    //   m_sent    : bytes already handed off in the current message
    //   m_ready_from : first cycle in which a byte may be released to uart_tx
    //   m_strobe / m_done : predicted for the current cycle
    // ------------------------------------------------------------------------
    bit         m_active = 0;
    int         m_sent   = 0;
    int         m_ready_from = 0;
    bit         m_strobe = 0;
    bit         m_done   = 0;
    logic [7:0] m_txd    = 8'h00;
    int         cyc      = 0;

    task automatic step(input logic st, input logic nrx, input logic [7:0] rxd,
                        input logic blk, input logic rs);
        bit trig, was_active, nxt_strobe, nxt_done;
        @(negedge clk);
        chk("busy",        32'(bus.busy),        32'(m_active));
        chk("done",        32'(bus.done),        32'(m_done));
        chk("tx_new_data", 32'(bus.tx_new_data), 32'(m_strobe));
        chk("rom_addr",    32'(bus.rom_addr),    m_active ? 32'(m_sent) : 32'd0);
        if (m_strobe) m_txd = msg[m_sent];
        chk("tx_data",     32'(bus.tx_data),     32'(m_txd));

        bus.start       = st;
        bus.new_rx_data = nrx;
        bus.rx_data     = rxd;
        bus.tx_block    = blk;
        rst             = rs;

        if (rs) begin
            m_active = 0; m_sent = 0; m_txd = 8'h00; m_strobe = 0; m_done = 0;
        end else begin
            trig       = st || (nrx && rxd == TRIG);
            was_active = m_active;
            nxt_strobe = 0;
            nxt_done   = 0;
            if (m_strobe) begin
                m_sent++;
                if (m_sent == MSG_LEN) begin
                    m_active = 0; m_sent = 0; nxt_done = 1;
                end else begin
                    m_ready_from = cyc + 2;
                end
            end else if (m_active && cyc >= m_ready_from && !bus.tx_busy && !blk) begin
                nxt_strobe = 1;
            end
            if (!was_active && trig) begin
                m_active = 1; m_sent = 0; m_ready_from = cyc + 2;
            end
            m_strobe = nxt_strobe;
            m_done   = nxt_done;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
    endtask

    task automatic run_to_idle();
        int k;
        k = 0;
        while (m_active && k < 3000) begin
            step(0, 0, 8'h00, 0, 0);
            k++;
        end
        if (m_active) chk("run_to_idle_timeout", 32'd1, 32'd0);
        idle(3);
    endtask

    task automatic wait_byte(input int b);
        int k;
        k = 0;
        while (!(m_active && m_sent == b) && k < 3000) begin
            step(0, 0, 8'h00, 0, 0);
            k++;
        end
        if (!(m_active && m_sent == b)) chk("wait_byte_timeout", 32'd1, 32'd0);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int k;
        bit exp_nd, exp_dn, exp_by;

        rst = 1'b1;
        bus.start = 0; bus.new_rx_data = 0; bus.rx_data = 8'h00; bus.tx_block = 0;
        bus1.start = 0; bus1.new_rx_data = 0; bus1.rx_data = 8'h00;
        bus1.tx_block = 0; bus1.tx_busy = 0;
        repeat (3) @(posedge clk);
        step(0, 0, 8'h00, 0, 1);     // reset values checked here
        idle(8);

        // start pulse, full message
        step(1, 0, 8'h00, 0, 0);
        run_to_idle();

        // non-matching character is ignored, matching one starts a message
        step(0, 1, 8'h67, 0, 0);
        idle(10);
        step(0, 1, TRIG, 0, 0);
        run_to_idle();

        // both trigger sources in the same cycle
        step(1, 1, TRIG, 0, 0);
        run_to_idle();

        // start every cycle during a message: no restart
        step(1, 0, 8'h00, 0, 0);
        k = 0;
        while (m_active && k < 3000) begin
            step(1, 1, TRIG, 0, 0);
            k++;
        end
        idle(3);

        // back-pressure on byte 5
        step(1, 0, 8'h00, 0, 0);
        wait_byte(5);
        for (int i = 0; i < 50; i++) step(0, 0, 8'h00, 1, 0);
        run_to_idle();

        // reset during byte 8, then a fresh message from byte 0
        step(1, 0, 8'h00, 0, 0);
        wait_byte(8);
        step(0, 0, 8'h00, 0, 1);
        idle(5);
        step(1, 0, 8'h00, 0, 0);

        // trigger in the done cycle launches the next message
        k = 0;
        while (!m_done && k < 3000) begin
            step(0, 0, 8'h00, 0, 0);
            k++;
        end
        if (!m_done) chk("done_timeout", 32'd1, 32'd0);
        step(1, 0, 8'h00, 0, 0);
        run_to_idle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic       st, nrx, blk;
            logic [7:0] rxd;
            int         sel;
            st  = ($urandom_range(0, 29) == 0);
            nrx = ($urandom_range(0, 9) == 0);
            sel = $urandom_range(0, 2);
            rxd = (sel == 0) ? TRIG : (sel == 1) ? 8'h67 : 8'($urandom);
            blk = ($urandom_range(0, 7) == 0);
            step(st, nrx, rxd, blk, 0);
        end
        run_to_idle();

        // MSG_LEN = 1 instance: start at offsets 0 and 4 (the done cycle)
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_nd = (i == 3) || (i == 7);
            exp_dn = (i == 4) || (i == 8);
            exp_by = (i >= 1 && i <= 3) || (i >= 5 && i <= 7);
            chk("len1_tx_new_data", 32'(bus1.tx_new_data), 32'(exp_nd));
            chk("len1_done",        32'(bus1.done),        32'(exp_dn));
            chk("len1_busy",        32'(bus1.busy),        32'(exp_by));
            chk("len1_rom_addr",    32'(bus1.rom_addr),    32'd0);
            if (exp_nd) chk("len1_tx_data", 32'(bus1.tx_data), 32'(msg[0]));
            bus1.start = (i == 0) || (i == 4);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
